aes256_cbc_framer: RTL and testbench



---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_pkcs7_padder.sv | 50 +++++
 rtl/aes256_cbc_framer.sv | 172 +++++++++++++++++
 tb/tb_aes256_cbc_framer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared types and constants for the AES-256-CBC job framer.
// Revision : 1.0
// ============================================================================
package aes_pkg;

    localparam int           AES_BLOCK_BYTES = 16;
    localparam logic [127:0] AES_PAD_BLOCK   = {16{8'h10}};

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_KEY_LO = 6'b000010,
        ST_KEY_HI = 6'b000100,
        ST_IV     = 6'b001000,
        ST_DATA   = 6'b010000,
        ST_PAD    = 6'b100000
    } framer_state_t;

endpackage
`default_nettype wire

// File: rtl/aes_pkcs7_padder.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkcs7_padder
// Purpose  : Combinational tail shaper: zero-fill or PKCS#7-fill of the bytes
//            after the leading run of tkeep ones.
// Revision : 1.0
// ============================================================================
module aes_pkcs7_padder
    import aes_pkg::*;
(
    input  logic [127:0] i_tdata,
    input  logic [15:0]  i_tkeep,
    input  logic         i_pad_en,
    output logic [127:0] o_block,
    output logic [4:0]   o_n,
    output logic         o_malformed
);

    logic [4:0]  w_n;
    logic        w_run;
    logic [15:0] w_mask;
    logic [7:0]  w_fill;

    // A gap in tkeep ends the run; later set bits are treated as missing.
    always_comb begin
        w_n   = '0;
        w_run = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            w_run = w_run & i_tkeep[i];
            w_n   = w_n + {4'd0, w_run};
        end
    end

    assign w_mask = ~(16'hFFFF >> w_n);
    assign w_fill = i_pad_en ? {3'b000, 5'd16 - w_n} : 8'h00;

    always_comb begin
        o_block = i_tdata;
        for (int b = 0; b < AES_BLOCK_BYTES; b++) begin
            if (5'(b) >= w_n) begin
                o_block[127-8*b -: 8] = w_fill;
            end
        end
    end

    assign o_n         = w_n;
    assign o_malformed = (i_tkeep != w_mask);

endmodule
`default_nettype wire

// File: rtl/aes256_cbc_framer.sv
`default_nettype none
// ============================================================================
// Module   : aes256_cbc_framer
// Purpose  : Builds the key/IV/payload job stream for the CBC cipher core.
//            Optional PKCS#7 tail padding when AES_PKCS7_PAD_EN is defined.
// Revision : 1.0
// ============================================================================
module aes256_cbc_framer
    import aes_pkg::*;
#(
    parameter int KEY_LENGTH = 256,
    parameter int BLOCK_SIZE = 128
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Cfg_valid,
    output logic                  Cfg_ready,
    input  logic [KEY_LENGTH-1:0] Cfg_key,
    input  logic [BLOCK_SIZE-1:0] Cfg_iv,
    input  logic                  Cfg_encrypt,
    input  logic                  S_axis_tvalid,
    output logic                  S_axis_tready,
    input  logic [BLOCK_SIZE-1:0] S_axis_tdata,
    input  logic [15:0]           S_axis_tkeep,
    input  logic                  S_axis_tlast,
    output logic                  M_axis_tvalid,
    input  logic                  M_axis_tready,
    output logic [BLOCK_SIZE-1:0] M_axis_tdata,
    output logic [15:0]           M_axis_tkeep,
    output logic                  M_axis_tlast,
    output logic                  M_axis_tuser,
    output logic [15:0]           Blocks_sent,
    output logic                  Err
);

    framer_state_t         r_state, w_next;
    logic [KEY_LENGTH-1:0] r_key;
    logic [BLOCK_SIZE-1:0] r_iv;
    logic                  r_enc;
    logic [15:0]           r_blocks;
    logic                  r_err;

    logic [127:0] w_blk;
    logic [4:0]   w_n;
    logic         w_malformed;
    logic         w_full, w_pad_tail, w_to_pad, w_bad;
    logic         w_cfg_hs, w_m_hs, w_s_hs;

    aes_pkcs7_padder u_padder (
        .i_tdata     (S_axis_tdata),
        .i_tkeep     (S_axis_tkeep),
        .i_pad_en    (w_pad_tail),
        .o_block     (w_blk),
        .o_n         (w_n),
        .o_malformed (w_malformed)
    );

    assign w_full = (w_n == 5'd16);
`ifdef AES_PKCS7_PAD_EN
    assign w_pad_tail = r_enc & S_axis_tlast;
`else
    assign w_pad_tail = 1'b0;
`endif
    // A full final encrypt beat still needs a whole pad block after it.
    assign w_to_pad = w_pad_tail & w_full;
    assign w_bad    = w_malformed | (~w_full & ~w_pad_tail);

    assign w_cfg_hs = Cfg_valid & (r_state == ST_IDLE);
    assign w_m_hs   = M_axis_tvalid & M_axis_tready;
    assign w_s_hs   = (r_state == ST_DATA) & S_axis_tvalid & M_axis_tready;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_key    <= '0;
            r_iv     <= '0;
            r_enc    <= 1'b0;
            r_blocks <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_s_hs & w_bad;
            if (w_cfg_hs) begin
                r_key    <= Cfg_key;
                r_iv     <= Cfg_iv;
                r_enc    <= Cfg_encrypt;
                r_blocks <= '0;
            end else if (w_m_hs && (r_state == ST_DATA || r_state == ST_PAD)) begin
                r_blocks <= r_blocks + 16'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (Cfg_valid) w_next = ST_KEY_LO;
            ST_KEY_LO: if (w_m_hs)    w_next = ST_KEY_HI;
            ST_KEY_HI: if (w_m_hs)    w_next = ST_IV;
            ST_IV:     if (w_m_hs)    w_next = ST_DATA;
            ST_DATA: begin
                if (w_s_hs && S_axis_tlast) begin
                    w_next = w_to_pad ? ST_PAD : ST_IDLE;
                end
            end
`ifdef AES_PKCS7_PAD_EN
            ST_PAD:    if (w_m_hs)    w_next = ST_IDLE;
`endif
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        Cfg_ready     = 1'b0;
        S_axis_tready = 1'b0;
        M_axis_tvalid = 1'b0;
        M_axis_tdata  = '0;
        M_axis_tkeep  = '0;
        M_axis_tlast  = 1'b0;
        M_axis_tuser  = 1'b0;
        case (r_state)
            ST_IDLE: Cfg_ready = 1'b1;
            ST_KEY_LO: begin
                M_axis_tvalid = 1'b1;
                M_axis_tdata  = r_key[BLOCK_SIZE-1:0];
                M_axis_tkeep  = 16'hFFFF;
                M_axis_tuser  = r_enc;
            end
            ST_KEY_HI: begin
                M_axis_tvalid = 1'b1;
                M_axis_tdata  = r_key[KEY_LENGTH-1:BLOCK_SIZE];
                M_axis_tkeep  = 16'hFFFF;
                M_axis_tuser  = r_enc;
            end
            ST_IV: begin
                M_axis_tvalid = 1'b1;
                M_axis_tdata  = r_iv;
                M_axis_tkeep  = 16'hFFFF;
                M_axis_tuser  = r_enc;
            end
            ST_DATA: begin
                M_axis_tvalid = S_axis_tvalid;
                S_axis_tready = M_axis_tready;
                M_axis_tdata  = w_blk;
                M_axis_tkeep  = 16'hFFFF;
                M_axis_tlast  = S_axis_tlast & ~w_to_pad;
                M_axis_tuser  = r_enc;
            end
`ifdef AES_PKCS7_PAD_EN
            ST_PAD: begin
                M_axis_tvalid = 1'b1;
                M_axis_tdata  = AES_PAD_BLOCK;
                M_axis_tkeep  = 16'hFFFF;
                M_axis_tlast  = 1'b1;
                M_axis_tuser  = r_enc;
            end
`endif
            default: ;
        endcase
    end

    assign Blocks_sent = r_blocks;
    assign Err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes256_cbc_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes256_cbc_framer
// Purpose  : Scoreboard bench for aes256_cbc_framer; expectations follow
//            AES_PKCS7_PAD_EN the same way the design build does.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_aes256_cbc_framer;

`ifdef AES_PKCS7_PAD_EN
    localparam bit c_PAD_EN = 1'b1;
`else
    localparam bit c_PAD_EN = 1'b0;
`endif
    localparam logic [255:0] c_KEY0 =
        256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         Cfg_valid = 1'b0, Cfg_encrypt = 1'b0;
    logic [255:0] Cfg_key = '0;
    logic [127:0] Cfg_iv = '0;
    logic         Cfg_ready;
    logic         S_axis_tvalid = 1'b0, S_axis_tlast = 1'b0;
    logic [127:0] S_axis_tdata = '0;
    logic [15:0]  S_axis_tkeep = '0;
    logic         S_axis_tready;
    logic         M_axis_tvalid, M_axis_tlast, M_axis_tuser;
    logic         M_axis_tready;
    logic [127:0] M_axis_tdata;
    logic [15:0]  M_axis_tkeep;
    logic [15:0]  Blocks_sent;
    logic         Err;

    aes256_cbc_framer dut (
        .Clk(Clk), .Rst(Rst),
        .Cfg_valid(Cfg_valid), .Cfg_ready(Cfg_ready), .Cfg_key(Cfg_key),
        .Cfg_iv(Cfg_iv), .Cfg_encrypt(Cfg_encrypt),
        .S_axis_tvalid(S_axis_tvalid), .S_axis_tready(S_axis_tready),
        .S_axis_tdata(S_axis_tdata), .S_axis_tkeep(S_axis_tkeep),
        .S_axis_tlast(S_axis_tlast),
        .M_axis_tvalid(M_axis_tvalid), .M_axis_tready(M_axis_tready),
        .M_axis_tdata(M_axis_tdata), .M_axis_tkeep(M_axis_tkeep),
        .M_axis_tlast(M_axis_tlast), .M_axis_tuser(M_axis_tuser),
        .Blocks_sent(Blocks_sent), .Err(Err)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
        logic         user;
    } beat_t;

    beat_t        sb[$];
    int           tests_run = 0;
    int           tests_failed = 0;
    int           err_cnt = 0;
    int           rdy_mode = 0;
    bit           prev_stall = 1'b0;
    logic [127:0] prev_data = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [127:0] d, input logic l, input logic u);
        beat_t b;
        b.data = d;
        b.last = l;
        b.user = u;
        sb.push_back(b);
    endtask

    function automatic int lead(input logic [15:0] k);
        int c = 0;
        for (int i = 15; i >= 0; i--) begin
            if (!k[i]) break;
            c++;
        end
        return c;
    endfunction

    function automatic logic [15:0] lmask(input int n);
        logic [15:0] m = '0;
        for (int i = 0; i < n; i++) m[15-i] = 1'b1;
        return m;
    endfunction

    function automatic logic [127:0] fill(input logic [127:0] d, input int n, input logic [7:0] v);
        logic [127:0] r = d;
        for (int b = n; b < 16; b++) r[127-8*b -: 8] = v;
        return r;
    endfunction

    // Sink-side ready pattern: 0 = always ready, 1 = random, 2 = never ready
    initial begin
        M_axis_tready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            case (rdy_mode)
                0:       M_axis_tready = 1'b1;
                1:       M_axis_tready = 1'($urandom_range(0, 1));
                default: M_axis_tready = 1'b0;
            endcase
        end
    end

    always @(negedge Clk) begin
        if (Rst) begin
            prev_stall = 1'b0;
        end else begin
            if (Err) err_cnt++;
            if (prev_stall) chk("stall_hold", M_axis_tdata, prev_data);
            if (M_axis_tvalid && M_axis_tready) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", M_axis_tdata, 128'hx);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("tdata", M_axis_tdata, e.data);
                    chk("tlast", M_axis_tlast, e.last);
                    chk("tuser", M_axis_tuser, e.user);
                    chk("tkeep", M_axis_tkeep, 16'hFFFF);
                end
            end
            prev_stall = M_axis_tvalid && !M_axis_tready;
            prev_data  = M_axis_tdata;
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (t < 2000) begin
            @(negedge Clk);
            if (Cfg_ready) break;
            t++;
        end
        if (t >= 2000) chk("timeout_idle", 0, 1);
    endtask

    task automatic run_job(input string name, input logic [255:0] key, input logic [127:0] iv,
                           input logic enc, input int nb, input logic [15:0] first_keep,
                           input logic [15:0] last_keep);
        logic [127:0] d;
        logic [15:0]  k;
        logic         last;
        int           n, exp_err, exp_blk, t;
        bit           hs;
        exp_err = 0;
        exp_blk = 0;
        wait_idle();
        @(posedge Clk);
        #1;
        Cfg_valid = 1'b1; Cfg_key = key; Cfg_iv = iv; Cfg_encrypt = enc;
        push(key[127:0], 1'b0, enc);
        push(key[255:128], 1'b0, enc);
        push(iv, 1'b0, enc);
        @(posedge Clk);
        err_cnt = 0;
        #1;
        Cfg_valid = 1'b0; Cfg_encrypt = ~enc; Cfg_key = ~key;
        @(negedge Clk);
        chk({name, "_first_valid"}, M_axis_tvalid, 1'b1);
        for (int i = 0; i < nb; i++) begin
            d    = {$urandom, $urandom, $urandom, $urandom};
            last = (i == nb - 1);
            k    = last ? last_keep : ((i == 0) ? first_keep : 16'hFFFF);
            n    = lead(k);
            if (!last) begin
                push(fill(d, n, 8'h00), 1'b0, enc);
                exp_blk++;
                if (k != 16'hFFFF) exp_err++;
            end else if (c_PAD_EN && enc) begin
                if (n == 16) begin
                    push(d, 1'b0, enc);
                    push({16{8'h10}}, 1'b1, enc);
                    exp_blk += 2;
                end else begin
                    push(fill(d, n, 8'(16 - n)), 1'b1, enc);
                    exp_blk++;
                    if (k != lmask(n)) exp_err++;
                end
            end else begin
                push(fill(d, n, 8'h00), 1'b1, enc);
                exp_blk++;
                if (k != 16'hFFFF) exp_err++;
            end
            S_axis_tvalid = 1'b1; S_axis_tdata = d; S_axis_tkeep = k; S_axis_tlast = last;
            hs = 1'b0;
            t  = 0;
            while (!hs && t < 2000) begin
                @(negedge Clk);
                hs = S_axis_tready;
                @(posedge Clk);
                #1;
                t++;
            end
            if (!hs) chk({name, "_timeout_beat"}, 0, 1);
        end
        S_axis_tvalid = 1'b0;
        S_axis_tlast  = 1'b0;
        wait_idle();
        @(negedge Clk);
        chk({name, "_sb_empty"}, sb.size(), 0);
        chk({name, "_blocks_sent"}, Blocks_sent, exp_blk);
        chk({name, "_err_count"}, err_cnt, exp_err);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_cfg_ready"}, Cfg_ready, 1'b1);
        chk({name, "_s_tready"}, S_axis_tready, 1'b0);
        chk({name, "_m_tvalid"}, M_axis_tvalid, 1'b0);
        chk({name, "_m_tdata"}, M_axis_tdata, 128'h0);
        chk({name, "_m_tkeep"}, M_axis_tkeep, 16'h0);
        chk({name, "_m_tlast"}, M_axis_tlast, 1'b0);
        chk({name, "_m_tuser"}, M_axis_tuser, 1'b0);
        chk({name, "_blocks"}, Blocks_sent, 16'h0);
        chk({name, "_err"}, Err, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_reset_outputs("reset");
        @(posedge Clk);
        #1 Rst = 1'b0;

        run_job("enc_full2", c_KEY0, 128'h0, 1'b1, 2, 16'hFFFF, 16'hFFFF);
        run_job("enc_tail12", c_KEY0, 128'hA5A5, 1'b1, 1, 16'hFFFF, 16'hFFF0);
        run_job("dec_tail8", ~c_KEY0, 128'h1234, 1'b0, 2, 16'hFFFF, 16'hFF00);
        rdy_mode = 1;
        run_job("enc_bp10", {8{32'hDEADBEEF}}, 128'hC0FFEE, 1'b1, 10, 16'hFFFF, 16'hFFFF);
        rdy_mode = 0;

        // Abort a job while the IV is stalled, then restart cleanly
        wait_idle();
        @(posedge Clk);
        #1;
        Cfg_valid = 1'b1; Cfg_key = c_KEY0; Cfg_iv = 128'h77; Cfg_encrypt = 1'b1;
        push(c_KEY0[127:0], 1'b0, 1'b1);
        push(c_KEY0[255:128], 1'b0, 1'b1);
        @(posedge Clk);
        #1 Cfg_valid = 1'b0;
        @(posedge Clk);
        #2 rdy_mode = 2;
        @(posedge Clk);
        #2;
        chk("rst_iv_visible", M_axis_tdata, 128'h77);
        Rst = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check_reset_outputs("midjob_rst");
        chk("midjob_rst_sb_empty", sb.size(), 0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        rdy_mode = 0;

        run_job("post_rst", c_KEY0, 128'h99, 1'b1, 1, 16'hFFFF, 16'hFFFF);
        run_job("enc_midpart", c_KEY0, 128'h1, 1'b1, 2, 16'hFF00, 16'hFFFF);
        run_job("dec_noncontig", c_KEY0, 128'h2, 1'b0, 1, 16'hFFFF, 16'hF0F0);
        run_job("enc_empty", c_KEY0, 128'h3, 1'b1, 1, 16'hFFFF, 16'h0000);
        run_job("enc_noncontig", c_KEY0, 128'h4, 1'b1, 2, 16'hFFFF, 16'hE080);
        rdy_mode = 1;
        run_job("enc_tail1_bp", c_KEY0, 128'h5, 1'b1, 3, 16'hFFFF, 16'h8000);
        rdy_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
